link_tx_framer: RTL

//  Upstream stage of the internode MGT link: takes flits from the router's internode output port,

---
 rtl/link_pkg.sv | 13 +
 rtl/link_tx_framer_if.sv | 17 +
 rtl/link_tx_fifo.sv | 40 ++++
 rtl/link_tx_framer.sv | 66 ++++++
 4 files changed

// File: rtl/link_pkg.sv
// link_pkg: word types, FSM states and word packing shared by the link tx path
package link_pkg;
  localparam int LINK_W = 64;
  localparam int LINK_FLIT_W = LINK_W - 2;
  localparam logic [1:0] LT_IDLE = 2'b00;
  localparam logic [1:0] LT_DATA = 2'b01;
  localparam logic [1:0] LT_CREDIT = 2'b10;
  localparam logic [1:0] LT_SYNC = 2'b11;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic logic [LINK_W-1:0] build_word(input logic [1:0] t, input logic [LINK_FLIT_W-1:0] p);
    return {t, p};
  endfunction
endpackage

// File: rtl/link_tx_framer_if.sv
// link_tx_framer_if: router flit port, credit inputs and MGT tx port of the framer
interface link_tx_framer_if #(parameter int WIDTH = 64, parameter int CNT_W = 5) ();
  logic in_valid;
  logic [WIDTH-3:0] in_data;
  logic in_ready;
  logic credit_ret_valid;
  logic [CNT_W-1:0] credit_ret_cnt;
  logic rx_buf_free;
  logic tx_ready;
  logic [WIDTH-1:0] tx_par_data;
  logic link_up;
  logic credit_err;
  modport master (output in_valid, in_data, credit_ret_valid, credit_ret_cnt, rx_buf_free, tx_ready,
                  input in_ready, tx_par_data, link_up, credit_err);
  modport slave (input in_valid, in_data, credit_ret_valid, credit_ret_cnt, rx_buf_free, tx_ready,
                 output in_ready, tx_par_data, link_up, credit_err);
endinterface

// File: rtl/link_tx_fifo.sv
// link_tx_fifo: flit buffer whose registered head becomes visible one edge after the push
module link_tx_fifo #(parameter int W = 62, parameter int DEPTH = 8) (
  input  logic         tx_clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0] cnt, vcnt;
  logic push_q;
  assign rd_next = rd_ptr + AW'(pop);
  assign full = cnt == (AW+1)'(DEPTH);
  // vcnt lags cnt by one edge so a new entry is only offered once head has loaded it
  assign empty = vcnt == '0;
  always_ff @(posedge tx_clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      vcnt <= '0;
      push_q <= 1'b0;
      head <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_next;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      vcnt <= vcnt + (AW+1)'(push_q) - (AW+1)'(pop);
      push_q <= push;
      head <= mem[rd_next];
    end
  end
endmodule

// File: rtl/link_tx_framer.sv
// link_tx_framer: frames router flits into SYNC/DATA/CREDIT/IDLE MGT words under credit flow control
module link_tx_framer
  import link_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FLIT_W = WIDTH - 2,
  parameter int FIFO_DEPTH = 8,
  parameter int REMOTE_DEPTH = 16,
  parameter int CNT_W = 5,
  parameter int CREDIT_BATCH = 4,
  parameter int INIT_SYNC = 16,
  parameter logic [FLIT_W-1:0] SYNC_PATTERN = 62'h2AAA_5555
) (
  input logic tx_clk,
  input logic rst,
  link_tx_framer_if.slave bus
);
  localparam int SW = $clog2(INIT_SYNC + 1);
  localparam logic [CNT_W:0] SAT = (CNT_W+1)'((1 << CNT_W) - 1);
  localparam logic [CNT_W:0] RD = (CNT_W+1)'(REMOTE_DEPTH);
  state_t state, state_nx;
  logic [SW-1:0] sync_cnt;
  logic [CNT_W-1:0] remote_cr, pending_cr;
  logic [CNT_W:0] pend_sum, rem_sum;
  logic [WIDTH-1:0] word_nx;
  logic [FLIT_W-1:0] head;
  logic fifo_full, fifo_empty, push, pop, have_data, send_cr, send_data, over;
  assign bus.in_ready = !fifo_full && !rst;
  assign bus.link_up = state == ST_RUN;
  assign push = bus.in_valid && bus.in_ready;
  link_tx_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .tx_clk(tx_clk), .rst(rst), .push(push), .din(bus.in_data), .pop(pop),
    .full(fifo_full), .empty(fifo_empty), .head(head)
  );
  always_comb begin
    have_data = !fifo_empty && remote_cr != '0;
    send_cr = state == ST_RUN && (pending_cr >= CNT_W'(CREDIT_BATCH) || (pending_cr != '0 && !have_data));
    send_data = state == ST_RUN && !send_cr && have_data;
    pop = bus.tx_ready && send_data;
    word_nx = state == ST_INIT ? build_word(LT_SYNC, SYNC_PATTERN)
            : send_cr ? build_word(LT_CREDIT, FLIT_W'(pending_cr))
            : send_data ? build_word(LT_DATA, head) : '0;
    state_nx = state == ST_INIT && bus.tx_ready && sync_cnt == SW'(INIT_SYNC - 1) ? ST_RUN : state;
    // pending_cr never exceeds SAT, so a CREDIT word always drains the whole count
    pend_sum = {1'b0, bus.tx_ready && send_cr ? '0 : pending_cr} + (CNT_W+1)'(bus.rx_buf_free);
    rem_sum = {1'b0, remote_cr} - (CNT_W+1)'(pop) + (bus.credit_ret_valid ? {1'b0, bus.credit_ret_cnt} : '0);
    over = rem_sum > RD;
  end
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state <= ST_INIT;
      sync_cnt <= '0;
      remote_cr <= CNT_W'(REMOTE_DEPTH);
      pending_cr <= '0;
      bus.tx_par_data <= '0;
      bus.credit_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.tx_ready) bus.tx_par_data <= word_nx;
      if (bus.tx_ready && state == ST_INIT) sync_cnt <= sync_cnt + SW'(1);
      pending_cr <= pend_sum > SAT ? SAT[CNT_W-1:0] : pend_sum[CNT_W-1:0];
      remote_cr <= over ? RD[CNT_W-1:0] : rem_sum[CNT_W-1:0];
      if (over) bus.credit_err <= 1'b1;
    end
  end
endmodule
